// File: rtl/fpu8_op_scheduler.sv
// Request-level controller for the 8-bit FPU: operand screening, datapath dispatch
// with watchdog, one response per request, sticky exception flags and completion count.

`ifndef _ADDITION
`define _ADDITION       2'b00
`endif
`ifndef _SUBTRACTION
`define _SUBTRACTION    2'b01
`endif
`ifndef _MULTIPLICATION
`define _MULTIPLICATION 2'b10
`endif
`ifndef _DIVISION
`define _DIVISION       2'b11
`endif
`ifndef _NO_EXCE
`define _NO_EXCE        3'b000
`endif
`ifndef _qNAN_EXCE
`define _qNAN_EXCE      3'b001
`endif
`ifndef _INF_EXCE
`define _INF_EXCE       3'b010
`endif
`ifndef _ZERO_DIV_EXCE
`define _ZERO_DIV_EXCE  3'b100
`endif

// Operand screen for the 1-4-3 float format (sign, 4-bit exponent, 3-bit mantissa).
module EXCEPTION_MODULE (
  input  logic [1:0] OP,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       OP_IS_EXCEPTION,
  output logic [2:0] FP_EXCE
);
  logic a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;

  assign a_nan_s  = (A[6:3] == 4'hF) && (A[2:0] != 3'b000);
  assign b_nan_s  = (B[6:3] == 4'hF) && (B[2:0] != 3'b000);
  assign a_inf_s  = (A[6:3] == 4'hF) && (A[2:0] == 3'b000);
  assign b_inf_s  = (B[6:3] == 4'hF) && (B[2:0] == 3'b000);
  assign a_zero_s = (A[6:0] == 7'd0);
  assign b_zero_s = (B[6:0] == 7'd0);

  // NaN inputs take priority over the operation-specific invalid cases
  always_comb begin
    FP_EXCE = `_NO_EXCE;
    if (a_nan_s || b_nan_s) begin
      FP_EXCE = `_qNAN_EXCE;
    end else begin
      case (OP)
        `_ADDITION:
          if (a_inf_s && b_inf_s && (A[7] != B[7])) FP_EXCE = `_INF_EXCE;
          else FP_EXCE = `_NO_EXCE;
        `_SUBTRACTION:
          if (a_inf_s && b_inf_s && (A[7] == B[7])) FP_EXCE = `_INF_EXCE;
          else FP_EXCE = `_NO_EXCE;
        `_MULTIPLICATION:
          if ((a_zero_s && b_inf_s) || (a_inf_s && b_zero_s)) FP_EXCE = `_INF_EXCE;
          else FP_EXCE = `_NO_EXCE;
        `_DIVISION:
          if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) FP_EXCE = `_INF_EXCE;
          else if (b_zero_s) FP_EXCE = `_ZERO_DIV_EXCE;
          else FP_EXCE = `_NO_EXCE;
        default: FP_EXCE = `_NO_EXCE;
      endcase
    end
  end

  assign OP_IS_EXCEPTION = (FP_EXCE != `_NO_EXCE);
endmodule

module fpu8_op_scheduler #(
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [7:0] QNAN_VALUE     = 8'h7F
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_OP,
  input  logic [7:0] REQ_A,
  input  logic [7:0] REQ_B,
  output logic       DP_START,
  output logic [1:0] DP_OP,
  output logic [7:0] DP_A,
  output logic [7:0] DP_B,
  input  logic       DP_DONE,
  input  logic [7:0] DP_RESULT,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_RESULT,
  output logic       RSP_IS_EXCE,
  output logic [2:0] RSP_EXCE,
  output logic       RSP_TIMEOUT,
  input  logic       FLAG_CLR,
  output logic [2:0] FLAGS,
  output logic [7:0] OP_COUNT
);
  localparam int WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_CHECK = 2'b01, ST_EXEC = 2'b10, ST_RESP = 2'b11} state_t;

  state_t state_r, next_state_s;
  logic            req_ready_r, dp_start_r, rsp_valid_r, rsp_is_exce_r, rsp_timeout_r;
  logic [1:0]      dp_op_r;
  logic [7:0]      dp_a_r, dp_b_r, rsp_result_r, op_count_r;
  logic [2:0]      rsp_exce_r, flags_r, flag_set_s, fp_exce_s;
  logic [WD_W-1:0] wd_cnt_r;
  logic            op_is_exce_s, accept_s, timeout_s;

  // Maps an exception code onto its sticky flag bit {divzero, invalid-inf, qNaN}
  function automatic logic [2:0] exce_to_flag(input logic [2:0] exce);
    case (exce)
      `_ZERO_DIV_EXCE: exce_to_flag = 3'b100;
      `_INF_EXCE:      exce_to_flag = 3'b010;
      `_qNAN_EXCE:     exce_to_flag = 3'b001;
      default:         exce_to_flag = 3'b000;
    endcase
  endfunction

  EXCEPTION_MODULE u_exce (
    .OP              (dp_op_r),
    .A               (dp_a_r),
    .B               (dp_b_r),
    .OP_IS_EXCEPTION (op_is_exce_s),
    .FP_EXCE         (fp_exce_s)
  );

  assign accept_s = (state_r == ST_IDLE) && REQ_VALID && req_ready_r;

  // Next-state decode; DP_DONE beats the watchdog when both land in the same cycle
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE:  if (accept_s) next_state_s = ST_CHECK; else next_state_s = ST_IDLE;
      ST_CHECK: if (op_is_exce_s) next_state_s = ST_RESP; else next_state_s = ST_EXEC;
      ST_EXEC: begin
        if (DP_DONE) begin
          next_state_s = ST_RESP;
        end else if (wd_cnt_r == WD_LIMIT) begin
          next_state_s = ST_RESP;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = ST_EXEC;
        end
      end
      ST_RESP:  if (RSP_READY) next_state_s = ST_IDLE; else next_state_s = ST_RESP;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Flag set only happens when an operand exception sends CHECK straight to RESP
  always_comb begin
    flag_set_s = 3'b000;
    if (state_r == ST_CHECK && op_is_exce_s) flag_set_s = exce_to_flag(fp_exce_s);
    else flag_set_s = 3'b000;
  end

  // State register and state-decoded handshake outputs, registered from next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      dp_start_r  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      req_ready_r <= (next_state_s == ST_IDLE);
      rsp_valid_r <= (next_state_s == ST_RESP);
      dp_start_r  <= (state_r == ST_CHECK) && (next_state_s == ST_EXEC);
    end
  end

  // Operand latch, held from CHECK through EXEC
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dp_op_r <= 2'b00;
      dp_a_r  <= 8'h00;
      dp_b_r  <= 8'h00;
    end else if (accept_s) begin
      dp_op_r <= REQ_OP;
      dp_a_r  <= REQ_A;
      dp_b_r  <= REQ_B;
    end else begin
      dp_op_r <= dp_op_r;
      dp_a_r  <= dp_a_r;
      dp_b_r  <= dp_b_r;
    end
  end

  // Watchdog: cleared while in CHECK so it starts at zero on EXEC entry
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if (state_r == ST_CHECK) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if (state_r == ST_EXEC && !DP_DONE && wd_cnt_r != WD_LIMIT) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Response payload, loaded on the transition into RESP and held until handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_result_r  <= 8'h00;
      rsp_is_exce_r <= 1'b0;
      rsp_exce_r    <= `_NO_EXCE;
      rsp_timeout_r <= 1'b0;
    end else if (state_r == ST_CHECK && op_is_exce_s) begin
      rsp_result_r  <= QNAN_VALUE;
      rsp_is_exce_r <= 1'b1;
      rsp_exce_r    <= fp_exce_s;
      rsp_timeout_r <= 1'b0;
    end else if (state_r == ST_EXEC && DP_DONE) begin
      rsp_result_r  <= DP_RESULT;
      rsp_is_exce_r <= 1'b0;
      rsp_exce_r    <= `_NO_EXCE;
      rsp_timeout_r <= 1'b0;
    end else if (timeout_s) begin
      rsp_result_r  <= QNAN_VALUE;
      rsp_is_exce_r <= 1'b1;
      rsp_exce_r    <= `_NO_EXCE;
      rsp_timeout_r <= 1'b1;
    end else begin
      rsp_result_r  <= rsp_result_r;
      rsp_is_exce_r <= rsp_is_exce_r;
      rsp_exce_r    <= rsp_exce_r;
      rsp_timeout_r <= rsp_timeout_r;
    end
  end

  // Sticky flags (a same-cycle set overrides the clear) and completion counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flags_r    <= 3'b000;
      op_count_r <= 8'h00;
    end else begin
      flags_r <= (FLAG_CLR ? 3'b000 : flags_r) | flag_set_s;
      if (state_r == ST_RESP && RSP_READY) op_count_r <= op_count_r + 8'd1;
      else op_count_r <= op_count_r;
    end
  end

  assign REQ_READY   = req_ready_r;
  assign DP_START    = dp_start_r;
  assign DP_OP       = dp_op_r;
  assign DP_A        = dp_a_r;
  assign DP_B        = dp_b_r;
  assign RSP_VALID   = rsp_valid_r;
  assign RSP_RESULT  = rsp_result_r;
  assign RSP_IS_EXCE = rsp_is_exce_r;
  assign RSP_EXCE    = rsp_exce_r;
  assign RSP_TIMEOUT = rsp_timeout_r;
  assign FLAGS       = flags_r;
  assign OP_COUNT    = op_count_r;
endmodule

// File: tb/tb_fpu8_op_scheduler.sv
// Scoreboard bench for fpu8_op_scheduler. Cycle 0 is the IDLE cycle whose closing
// edge samples the request handshake; latencies count cycles from there.
module tb_fpu8_op_scheduler;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;
  localparam logic [2:0] EX_NONE = 3'b000, EX_QNAN = 3'b001, EX_INF = 3'b010, EX_DIVZ = 3'b100;

  logic       CLK = 1'b0, RST;
  logic       REQ_VALID, REQ_READY, DP_START, DP_DONE, RSP_VALID, RSP_READY;
  logic       RSP_IS_EXCE, RSP_TIMEOUT, FLAG_CLR;
  logic [1:0] REQ_OP, DP_OP;
  logic [7:0] REQ_A, REQ_B, DP_A, DP_B, DP_RESULT, RSP_RESULT, OP_COUNT;
  logic [2:0] RSP_EXCE, FLAGS;

  typedef struct {
    logic [7:0] result;
    logic       is_exce;
    logic [2:0] exce;
    logic       timeout;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0, n_fail = 0;
  int dp_delay = 0, dp_cnt = 0, dp_starts = 0;
  logic [7:0] dp_value = 8'h00;
  logic force_done = 1'b0;

  always #5 CLK = ~CLK;

  fpu8_op_scheduler #(.TIMEOUT_CYCLES(16), .QNAN_VALUE(8'h7F)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .DP_START(DP_START), .DP_OP(DP_OP), .DP_A(DP_A), .DP_B(DP_B),
    .DP_DONE(DP_DONE), .DP_RESULT(DP_RESULT), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RESULT(RSP_RESULT), .RSP_IS_EXCE(RSP_IS_EXCE), .RSP_EXCE(RSP_EXCE),
    .RSP_TIMEOUT(RSP_TIMEOUT), .FLAG_CLR(FLAG_CLR), .FLAGS(FLAGS), .OP_COUNT(OP_COUNT)
  );

  // Datapath stub: raises DP_DONE in EXEC cycle dp_delay (0 = never), or when forced
  initial begin
    DP_DONE = 1'b0;
    DP_RESULT = 8'h00;
    forever begin
      @(posedge CLK); #2;
      if (RST) dp_cnt = 0;
      else if (DP_START) begin dp_cnt = 1; dp_starts++; end
      else if (dp_cnt != 0 && dp_cnt < 40) dp_cnt++;
      else dp_cnt = 0;
      DP_RESULT = dp_value;
      DP_DONE = force_done || (dp_delay != 0 && dp_cnt == dp_delay);
      if (dp_delay != 0 && dp_cnt == dp_delay) dp_cnt = 0;
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
    REQ_OP = op; REQ_A = a; REQ_B = b; REQ_VALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (REQ_READY) ok = 1'b1;
      step();
    end
    REQ_VALID = 1'b0;
  endtask

  // Waits (bounded) for RSP_VALID; reports the cycle it was seen and the DP_START cycle
  task automatic get_rsp(input int start, output int lat, output int start_cyc, output bit seen);
    lat = start; start_cyc = 0; seen = 1'b0;
    while (lat < 60) begin
      if (DP_START && start_cyc == 0) start_cyc = lat;
      if (RSP_VALID) begin seen = 1'b1; break; end
      step();
      lat++;
    end
  endtask

  task automatic finish_rsp();
    RSP_READY = 1'b1; step(); RSP_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; step(); step();
    n_tests++;
    if ({REQ_READY, DP_START, DP_OP, DP_A, DP_B, RSP_VALID, RSP_RESULT, RSP_IS_EXCE, RSP_EXCE,
         RSP_TIMEOUT, FLAGS, OP_COUNT} !== {1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0,
         EX_NONE, 1'b0, 3'b000, 8'h00}) begin
      n_fail++; $display("FAIL reset_values: REQ_READY=%b RSP_VALID=%b FLAGS=%b OP_COUNT=%h want 1 0 000 00",
                         REQ_READY, RSP_VALID, FLAGS, OP_COUNT);
    end
    RST = 1'b0; step();
    n_tests++;
    if ({REQ_READY, RSP_VALID, DP_START, OP_COUNT} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL after_reset_idle: REQ_READY=%b RSP_VALID=%b DP_START=%b want 1 0 0",
                         REQ_READY, RSP_VALID, DP_START);
    end
  endtask

  task automatic test_add_clean();
    exp_t e; int lat, sc; bit ok, seen;
    dp_delay = 3; dp_value = 8'h30; dp_starts = 0;
    sb_q.push_back('{8'h30, 1'b0, EX_NONE, 1'b0, 5});
    issue(OP_ADD, 8'h20, 8'h28, ok);
    n_tests++;
    if ({ok, DP_OP, DP_A, DP_B} !== {1'b1, OP_ADD, 8'h20, 8'h28}) begin
      n_fail++; $display("FAIL add_latch: ok=%b op=%b a=%h b=%h want 1 00 20 28", ok, DP_OP, DP_A, DP_B);
    end
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || lat !== e.lat) begin n_fail++; $display("FAIL add_latency: got %0d want %0d", lat, e.lat); end
    n_tests++;
    if ({RSP_RESULT, RSP_IS_EXCE, RSP_EXCE, RSP_TIMEOUT} !== {e.result, e.is_exce, e.exce, e.timeout}) begin
      n_fail++; $display("FAIL add_rsp: got %h/%b/%b/%b want %h/%b/%b/%b", RSP_RESULT, RSP_IS_EXCE,
                         RSP_EXCE, RSP_TIMEOUT, e.result, e.is_exce, e.exce, e.timeout);
    end
    n_tests++;
    if (sc !== 2 || dp_starts !== 1) begin
      n_fail++; $display("FAIL add_dp_start: cycle %0d pulses %0d want cycle 2 pulses 1", sc, dp_starts);
    end
    finish_rsp();
    n_tests++;
    if (OP_COUNT !== 8'h01) begin n_fail++; $display("FAIL add_op_count: got %h want 01", OP_COUNT); end
  endtask

  task automatic test_div_zero();
    exp_t e; int lat, sc; bit ok, seen;
    dp_starts = 0;
    sb_q.push_back('{8'h7F, 1'b1, EX_DIVZ, 1'b0, 2});
    issue(OP_DIV, 8'h20, 8'h00, ok);
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!ok || !seen || lat !== e.lat) begin n_fail++; $display("FAIL divz_latency: got %0d want %0d", lat, e.lat); end
    n_tests++;
    if ({RSP_RESULT, RSP_IS_EXCE, RSP_EXCE, RSP_TIMEOUT} !== {e.result, e.is_exce, e.exce, e.timeout}) begin
      n_fail++; $display("FAIL divz_rsp: got %h/%b/%b/%b want %h/%b/%b/%b", RSP_RESULT, RSP_IS_EXCE,
                         RSP_EXCE, RSP_TIMEOUT, e.result, e.is_exce, e.exce, e.timeout);
    end
    n_tests++;
    if (sc !== 0 || dp_starts !== 0 || FLAGS !== 3'b100) begin
      n_fail++; $display("FAIL divz_flags_nostart: starts %0d flags %b want 0 100", dp_starts, FLAGS);
    end
    finish_rsp();
    FLAG_CLR = 1'b1; step(); FLAG_CLR = 1'b0;
    n_tests++;
    if (FLAGS !== 3'b000) begin n_fail++; $display("FAIL flag_clr: got %b want 000", FLAGS); end
  endtask

  task automatic test_flags();
    exp_t e; int lat, sc; bit ok, seen;
    sb_q.push_back('{8'h7F, 1'b1, EX_QNAN, 1'b0, 2});
    sb_q.push_back('{8'h7F, 1'b1, EX_INF, 1'b0, 2});
    sb_q.push_back('{8'h7F, 1'b1, EX_DIVZ, 1'b0, 2});
    issue(OP_MUL, 8'h7F, 8'h38, ok);
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || RSP_EXCE !== e.exce || FLAGS !== 3'b001) begin
      n_fail++; $display("FAIL nan_mul: exce %b flags %b want %b 001", RSP_EXCE, FLAGS, e.exce);
    end
    finish_rsp();
    issue(OP_ADD, 8'h78, 8'hF8, ok);
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || RSP_EXCE !== e.exce || RSP_RESULT !== e.result || FLAGS !== 3'b011) begin
      n_fail++; $display("FAIL inf_add: exce %b result %h flags %b want %b %h 011", RSP_EXCE, RSP_RESULT, FLAGS, e.exce, e.result);
    end
    finish_rsp();
    repeat (4) step();
    n_tests++;
    if (FLAGS !== 3'b011) begin n_fail++; $display("FAIL flags_sticky: got %b want 011", FLAGS); end
    issue(OP_DIV, 8'h38, 8'h00, ok);
    FLAG_CLR = 1'b1; step(); FLAG_CLR = 1'b0;
    get_rsp(2, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || lat !== e.lat || RSP_EXCE !== e.exce || FLAGS !== 3'b100) begin
      n_fail++; $display("FAIL clr_vs_set: lat %0d exce %b flags %b want %0d %b 100", lat, RSP_EXCE, FLAGS, e.lat, e.exce);
    end
    finish_rsp();
  endtask

  task automatic test_timeout();
    exp_t e; int lat, sc; bit ok, seen; logic [7:0] cnt;
    dp_delay = 0; dp_starts = 0;
    sb_q.push_back('{8'h7F, 1'b1, EX_NONE, 1'b1, 19});
    sb_q.push_back('{8'h42, 1'b0, EX_NONE, 1'b0, 19});
    sb_q.push_back('{8'h5A, 1'b0, EX_NONE, 1'b0, 3});
    issue(OP_MUL, 8'h38, 8'h38, ok);
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || lat !== e.lat) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", lat, e.lat); end
    n_tests++;
    if ({RSP_RESULT, RSP_IS_EXCE, RSP_EXCE, RSP_TIMEOUT, FLAGS} !== {e.result, e.is_exce, e.exce, e.timeout, 3'b100}) begin
      n_fail++; $display("FAIL timeout_rsp: got %h/%b/%b/%b flags %b want %h/%b/%b/%b flags 100", RSP_RESULT,
                         RSP_IS_EXCE, RSP_EXCE, RSP_TIMEOUT, FLAGS, e.result, e.is_exce, e.exce, e.timeout);
    end
    finish_rsp();
    cnt = OP_COUNT; dp_value = 8'h55;
    force_done = 1'b1; step(); force_done = 1'b0; step(); step();
    n_tests++;
    if ({RSP_VALID, REQ_READY, OP_COUNT} !== {1'b0, 1'b1, cnt}) begin
      n_fail++; $display("FAIL late_done_idle: RSP_VALID=%b REQ_READY=%b count %h want 0 1 %h", RSP_VALID, REQ_READY, OP_COUNT, cnt);
    end
    dp_delay = 17; dp_value = 8'h42;
    issue(OP_SUB, 8'h38, 8'h20, ok);
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || lat !== e.lat || {RSP_RESULT, RSP_IS_EXCE, RSP_TIMEOUT} !== {e.result, e.is_exce, e.timeout}) begin
      n_fail++; $display("FAIL done_at_limit: lat %0d got %h/%b/%b want %0d %h/%b/%b", lat, RSP_RESULT,
                         RSP_IS_EXCE, RSP_TIMEOUT, e.lat, e.result, e.is_exce, e.timeout);
    end
    finish_rsp();
    dp_delay = 1; dp_value = 8'h5A;
    issue(OP_DIV, 8'h40, 8'h38, ok);
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || lat !== e.lat || RSP_RESULT !== e.result) begin
      n_fail++; $display("FAIL done_first_cycle: lat %0d result %h want %0d %h", lat, RSP_RESULT, e.lat, e.result);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    exp_t e; int lat, sc; bit ok, seen; logic [12:0] held;
    dp_delay = 1; dp_value = 8'h48;
    sb_q.push_back('{8'h7F, 1'b1, EX_DIVZ, 1'b0, 2});
    sb_q.push_back('{8'h48, 1'b0, EX_NONE, 1'b0, 3});
    issue(OP_DIV, 8'h20, 8'h00, ok);
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || RSP_EXCE !== e.exce) begin n_fail++; $display("FAIL bp_first: exce %b want %b", RSP_EXCE, e.exce); end
    held = {RSP_RESULT, RSP_IS_EXCE, RSP_EXCE, RSP_TIMEOUT};
    REQ_OP = OP_ADD; REQ_A = 8'h20; REQ_B = 8'h28; REQ_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({RSP_VALID, REQ_READY, RSP_RESULT, RSP_IS_EXCE, RSP_EXCE, RSP_TIMEOUT} !== {1'b1, 1'b0, held}) begin
        n_fail++; $display("FAIL bp_hold_%0d: valid %b ready %b rsp %h want 1 0 %h", i, RSP_VALID, REQ_READY,
                           {RSP_RESULT, RSP_IS_EXCE, RSP_EXCE, RSP_TIMEOUT}, held);
      end
      step();
    end
    finish_rsp();
    n_tests++;
    if ({REQ_READY, RSP_VALID} !== 2'b10) begin
      n_fail++; $display("FAIL bp_idle: REQ_READY=%b RSP_VALID=%b want 1 0", REQ_READY, RSP_VALID);
    end
    step(); REQ_VALID = 1'b0;
    n_tests++;
    if ({REQ_READY, DP_A, DP_B} !== {1'b0, 8'h20, 8'h28}) begin
      n_fail++; $display("FAIL bp_accept: ready %b a %h b %h want 0 20 28", REQ_READY, DP_A, DP_B);
    end
    get_rsp(1, lat, sc, seen);
    e = sb_q.pop_front();
    n_tests++;
    if (!seen || lat !== e.lat || RSP_RESULT !== e.result) begin
      n_fail++; $display("FAIL bp_second: lat %0d result %h want %0d %h", lat, RSP_RESULT, e.lat, e.result);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [17:0] ops[4]; int cyc, last, acc, done; bit took;
    ops[0] = {OP_SUB, 8'h78, 8'h78}; ops[1] = {OP_MUL, 8'h00, 8'h78};
    ops[2] = {OP_DIV, 8'h78, 8'hF8}; ops[3] = {OP_ADD, 8'h38, 8'hFF};
    sb_q.push_back('{8'h7F, 1'b1, EX_INF, 1'b0, 2});
    sb_q.push_back('{8'h7F, 1'b1, EX_INF, 1'b0, 2});
    sb_q.push_back('{8'h7F, 1'b1, EX_INF, 1'b0, 2});
    sb_q.push_back('{8'h7F, 1'b1, EX_QNAN, 1'b0, 2});
    FLAG_CLR = 1'b1; step(); FLAG_CLR = 1'b0;
    {REQ_OP, REQ_A, REQ_B} = ops[0]; REQ_VALID = 1'b1; RSP_READY = 1'b1;
    cyc = 0; last = -1; acc = 0; done = 0;
    while (done < 4 && cyc < 100) begin
      took = 1'b0;
      if (RSP_VALID) begin
        e = sb_q.pop_front(); done++;
        n_tests++;
        if ({RSP_RESULT, RSP_EXCE} !== {e.result, e.exce}) begin
          n_fail++; $display("FAIL b2b_rsp_%0d: got %h/%b want %h/%b", done, RSP_RESULT, RSP_EXCE, e.result, e.exce);
        end
      end
      if (REQ_VALID && REQ_READY) begin
        if (last >= 0) begin
          n_tests++;
          if (cyc - last !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last); end
        end
        last = cyc; acc++; took = 1'b1;
      end
      step(); cyc++;
      if (took) begin
        if (acc < 4) {REQ_OP, REQ_A, REQ_B} = ops[acc];
        else REQ_VALID = 1'b0;
      end
    end
    RSP_READY = 1'b0; REQ_VALID = 1'b0;
    n_tests++;
    if (done !== 4 || FLAGS !== 3'b011) begin
      n_fail++; $display("FAIL b2b_done: responses %0d flags %b want 4 011", done, FLAGS);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok; bit bad;
    dp_delay = 0;
    issue(OP_ADD, 8'h20, 8'h28, ok);
    step(); step();
    RST = 1'b1; #1;
    n_tests++;
    if ({REQ_READY, DP_START, DP_OP, DP_A, DP_B, RSP_VALID, RSP_RESULT, RSP_IS_EXCE, RSP_EXCE,
         RSP_TIMEOUT, FLAGS, OP_COUNT} !== {1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0,
         EX_NONE, 1'b0, 3'b000, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset_values: ready %b start %b a %h valid %b flags %b count %h",
                         REQ_READY, DP_START, DP_A, RSP_VALID, FLAGS, OP_COUNT);
    end
    step(); step(); RST = 1'b0;
    force_done = 1'b1; dp_value = 8'h66; step(); force_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (RSP_VALID !== 1'b0 || DP_START !== 1'b0 || REQ_READY !== 1'b1) bad = 1'b1;
      step();
    end
    n_tests++;
    if (bad !== 1'b0 || OP_COUNT !== 8'h00 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL mid_reset_no_rsp: spurious activity %b count %h want 0 00", bad, OP_COUNT);
    end
  endtask

  task automatic test_wrap();
    int lat, sc; bit ok, seen;
    RSP_READY = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue(OP_DIV, 8'h30, 8'h00, ok);
      get_rsp(1, lat, sc, seen);
      n_tests++;
      if (!seen || RSP_EXCE !== EX_DIVZ) begin
        n_fail++; $display("FAIL wrap_rsp_%0d: seen %b exce %b want 1 %b", i, seen, RSP_EXCE, EX_DIVZ);
      end
      step();
      if (i == 254) begin
        n_tests++;
        if (OP_COUNT !== 8'hFF) begin n_fail++; $display("FAIL count_ff: got %h want ff", OP_COUNT); end
      end
    end
    RSP_READY = 1'b0;
    n_tests++;
    if (OP_COUNT !== 8'h00) begin n_fail++; $display("FAIL count_wrap: got %h want 00", OP_COUNT); end
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = 2'b00; REQ_A = 8'h00; REQ_B = 8'h00;
    RSP_READY = 1'b0; FLAG_CLR = 1'b0;
    test_reset();
    test_add_clean();
    test_div_zero();
    test_flags();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
